// File: rtl/encoder_event_ctrl.sv
// encoder_event_ctrl
//   Per-channel saturating signed position counters fed by encoder up/down
//   pulses, plus a round-robin arbiter that turns "position changed" flags
//   into a single valid/ready event stream.
//   Optional build macro: ENC_ACCEL_EN (same-direction pulses arriving within
//   ACCEL_WIN cycles of each other step by ACCEL_STEP instead of 1).
module encoder_event_ctrl #(
  parameter int N_ENC      = 4,
  parameter int POS_W      = 8,
  parameter int CH_W       = (N_ENC > 1) ? $clog2(N_ENC) : 1,
  parameter int ACCEL_WIN  = 1024,
  parameter int ACCEL_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_ENC-1:0]         up,
  input  logic [N_ENC-1:0]         down,
  input  logic [N_ENC-1:0]         clr,
  output logic [N_ENC*POS_W-1:0]   pos,
  output logic [N_ENC-1:0]         sat,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [CH_W-1:0]          ev_chan,
  output logic [POS_W-1:0]         ev_pos
);

  localparam int MAXV = (2 ** (POS_W - 1)) - 1;
  localparam int MINV = -(2 ** (POS_W - 1));

  // Reject out-of-range configurations at elaboration time.
  if (N_ENC < 1 || N_ENC > 16 || POS_W < 4 || POS_W > 16 ||
      ACCEL_WIN < 1 || ACCEL_STEP < 1) begin : g_param_check
    $error("encoder_event_ctrl: parameter out of range");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic signed [POS_W-1:0] r_pos      [N_ENC];
  logic signed [POS_W-1:0] w_pos_nxt  [N_ENC];
  logic signed [31:0]      w_sum      [N_ENC];
  logic signed [31:0]      w_step     [N_ENC];
  logic [N_ENC-1:0]        r_sat;
  logic [N_ENC-1:0]        w_sat_nxt;
  logic [N_ENC-1:0]        w_chg;
  logic [N_ENC-1:0]        r_pend;
  logic [N_ENC-1:0]        w_pend_nxt;
  logic [CH_W-1:0]         r_ptr;
  logic [CH_W-1:0]         w_gnt;
  logic                    w_any;
  logic                    w_fire;
  logic [CH_W-1:0]         r_ev_chan;
  logic [POS_W-1:0]        r_ev_pos;

`ifdef ENC_ACCEL_EN
  localparam int ACW = $clog2(ACCEL_WIN + 1);
  localparam logic [ACW-1:0]    WIN_C    = ACW'(ACCEL_WIN);
  localparam logic signed [31:0] STEP_ACC = 32'(ACCEL_STEP);

  logic [ACW-1:0]   r_acc_cnt [N_ENC];
  logic [N_ENC-1:0] r_acc_dir;

  // Acceleration window tracking: restart on each accepted pulse, park at
  // ACCEL_WIN when idle. Reset parks the counter so the first pulse is a
  // single step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_ENC; i++) r_acc_cnt[i] <= WIN_C;
      r_acc_dir <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ENC; i++) begin
        if (clr[i]) begin
          r_acc_cnt[i] <= WIN_C;
        end else if (up[i] ^ down[i]) begin
          r_acc_cnt[i] <= '0;
          r_acc_dir[i] <= up[i];
        end else if (r_acc_cnt[i] < WIN_C) begin
          r_acc_cnt[i] <= r_acc_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Step size per channel from the acceleration window.
  always_comb begin
    for (int unsigned i = 0; i < N_ENC; i++) begin
      w_step[i] = 32'sd1;
      if (r_acc_cnt[i] < WIN_C && r_acc_dir[i] == up[i]) w_step[i] = STEP_ACC;
    end
  end
`else
  // Fixed unit step.
  always_comb begin
    for (int unsigned i = 0; i < N_ENC; i++) w_step[i] = 32'sd1;
  end
`endif

  // Next position / sat / changed per channel: clear, cancel, clamped step.
  always_comb begin
    for (int unsigned i = 0; i < N_ENC; i++) begin
      w_pos_nxt[i] = r_pos[i];
      w_sat_nxt[i] = r_sat[i];
      w_chg[i]     = 1'b0;
      w_sum[i]     = '0;
      if (clr[i]) begin
        w_pos_nxt[i] = '0;
        w_sat_nxt[i] = 1'b0;
        w_chg[i]     = (r_pos[i] != '0);
      end else if (up[i] ^ down[i]) begin
        w_sum[i] = up[i] ? (32'(r_pos[i]) + w_step[i]) : (32'(r_pos[i]) - w_step[i]);
        if (w_sum[i] > MAXV) begin
          w_pos_nxt[i] = POS_W'(MAXV);
          w_sat_nxt[i] = 1'b1;
        end else if (w_sum[i] < MINV) begin
          w_pos_nxt[i] = POS_W'(MINV);
          w_sat_nxt[i] = 1'b1;
        end else begin
          w_pos_nxt[i] = POS_W'(w_sum[i]);
        end
        w_chg[i] = (w_pos_nxt[i] != r_pos[i]);
      end
    end
  end

  // Round-robin scan: first pending channel after the pointer.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int unsigned k = 1; k <= N_ENC; k++) begin
      if (!w_any && r_pend[CH_W'((32'(r_ptr) + k) % N_ENC)]) begin
        w_any = 1'b1;
        w_gnt = CH_W'((32'(r_ptr) + k) % N_ENC);
      end
    end
  end

  // Arbiter next-state and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_fire      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ev_ready) begin
          if (w_any) w_fire = 1'b1;
          else       w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending update: a change in the grant cycle re-arms the bit (set wins).
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_fire) w_pend_nxt[w_gnt] = 1'b0;
    w_pend_nxt = w_pend_nxt | w_chg;
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Event payload and round-robin pointer, captured on grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ev_chan <= '0;
      r_ev_pos  <= '0;
      r_ptr     <= CH_W'(N_ENC - 1);
    end else if (w_fire) begin
      r_ev_chan <= w_gnt;
      r_ev_pos  <= r_pos[w_gnt];
      r_ptr     <= w_gnt;
    end
  end

  // Position, saturation and pending registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_ENC; i++) r_pos[i] <= '0;
      r_sat  <= '0;
      r_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ENC; i++) r_pos[i] <= w_pos_nxt[i];
      r_sat  <= w_sat_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  // Flatten positions onto the parallel output bus.
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < N_ENC; i++) pos[i*POS_W +: POS_W] = r_pos[i];
  end

  assign sat      = r_sat;
  assign ev_valid = (r_state == S_HOLD);
  assign ev_chan  = r_ev_chan;
  assign ev_pos   = r_ev_pos;

endmodule

// File: tb/tb_encoder_event_ctrl.sv
// Directed bench for encoder_event_ctrl (N_ENC=4, POS_W=8).
module tb_encoder_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  up, down, clr;
  logic [31:0] pos;
  logic [3:0]  sat;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_chan;
  logic [7:0]  ev_pos;

  int total = 0;
  int bad   = 0;

  encoder_event_ctrl #(.N_ENC(4), .POS_W(8), .ACCEL_WIN(1024), .ACCEL_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .up(up), .down(down), .clr(clr),
    .pos(pos), .sat(sat), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_pos(ev_pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gp(input int ch);
    return pos[ch*8 +: 8];
  endfunction

  task automatic do_reset();
    up = '0; down = '0; clr = '0; ev_ready = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pos !== 32'h0) begin bad++; $display("FAIL reset_pos got=%h exp=%h", pos, 32'h0); end
    total++; if (sat !== 4'h0) begin bad++; $display("FAIL reset_sat got=%h exp=%h", sat, 4'h0); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ev_valid); end
    total++; if (ev_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", ev_chan); end
    total++; if (ev_pos !== 8'd0) begin bad++; $display("FAIL reset_evpos got=%0d exp=0", ev_pos); end
    // reset while an event is held
    up = 4'b0010; tick(); up = '0; tick();
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", ev_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b exp=0", ev_valid); end
    tick(); reset_n = 1'b1; tick(); tick(); tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b exp=0", ev_valid); end
    total++; if (gp(1) !== 8'd0) begin bad++; $display("FAIL midrst_pos got=%0d exp=0", gp(1)); end
  endtask

  task automatic test_latency();
    do_reset();
    up = 4'b0010; tick(); up = '0;
    total++; if (gp(1) !== 8'd1) begin bad++; $display("FAIL lat_pos got=%0d exp=1", gp(1)); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", ev_valid); end
    tick();
    total++; if ({ev_valid, ev_chan, ev_pos} !== {1'b1, 2'd1, 8'd1}) begin bad++;
      $display("FAIL lat_event got=%b/%0d/%0d exp=1/1/1", ev_valid, ev_chan, ev_pos); end
    ev_ready = 1'b1; tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL lat_done got=%b exp=0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int n_ev;
    logic [7:0] last;
    do_reset();
    ev_ready = 1'b1; n_ev = 0; last = '0;
    for (int i = 0; i < 130; i++) begin
      up = 4'b0001; tick();
      if (ev_valid) begin n_ev++; last = ev_pos; end
    end
    up = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ev_valid) begin n_ev++; last = ev_pos; end
    end
    total++; if (gp(0) !== 8'd127) begin bad++; $display("FAIL sat_pos got=%0d exp=127", gp(0)); end
    total++; if (sat[0] !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat[0]); end
    total++; if (n_ev !== 127) begin bad++; $display("FAIL sat_events got=%0d exp=127", n_ev); end
    total++; if (last !== 8'd127) begin bad++; $display("FAIL sat_last got=%0d exp=127", last); end
    down = 4'b0001; tick(); down = '0;
    total++; if (gp(0) !== 8'd126) begin bad++; $display("FAIL sat_down got=%0d exp=126", gp(0)); end
    for (int i = 0; i < 4; i++) tick();
    clr = 4'b0001; tick(); clr = '0;
    total++; if ({gp(0), sat[0]} !== {8'd0, 1'b0}) begin bad++;
      $display("FAIL sat_clr got=%0d/%b exp=0/0", gp(0), sat[0]); end
    for (int i = 0; i < 4; i++) tick();
    ev_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_ch [4];
    int exp_ps [4];
    do_reset();
    ev_ready = 1'b1;
    exp_ch = '{0, 2, 3, 0};
    up = 4'b1101; tick(); up = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++; if ({ev_valid, ev_chan, ev_pos} !== {1'b1, 2'(exp_ch[j]), 8'd1}) begin bad++;
        $display("FAIL b2b_r1_%0d got=%b/%0d/%0d exp=1/%0d/1", j, ev_valid, ev_chan, ev_pos, exp_ch[j]); end
    end
    tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL b2b_r1_end got=%b exp=0", ev_valid); end
    exp_ch = '{0, 1, 2, 3};
    exp_ps = '{2, 1, 2, 2};
    up = 4'b1111; tick(); up = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      total++; if ({ev_valid, ev_chan, ev_pos} !== {1'b1, 2'(exp_ch[j]), 8'(exp_ps[j])}) begin bad++;
        $display("FAIL b2b_r2_%0d got=%b/%0d/%0d exp=1/%0d/%0d", j, ev_valid, ev_chan, ev_pos, exp_ch[j], exp_ps[j]); end
    end
    tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL b2b_r2_end got=%b exp=0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_hold_stable();
    logic stable_ok;
    do_reset();
    ev_ready = 1'b0; stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      up = ((c % 3 == 0) && (c < 15)) ? 4'b0010 : 4'b0000;
      tick();
      if (c >= 1 && !(ev_valid === 1'b1 && ev_chan === 2'd1 && ev_pos === 8'd1)) stable_ok = 1'b0;
    end
    up = '0;
    total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL hold_stable got=%b exp=1", stable_ok); end
    total++; if (gp(1) !== 8'd5) begin bad++; $display("FAIL hold_pos got=%0d exp=5", gp(1)); end
    ev_ready = 1'b1; tick();
    total++; if ({ev_valid, ev_chan, ev_pos} !== {1'b1, 2'd1, 8'd5}) begin bad++;
      $display("FAIL hold_second got=%b/%0d/%0d exp=1/1/5", ev_valid, ev_chan, ev_pos); end
    tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL hold_end got=%b exp=0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_cancel_clr();
    int seen;
    logic [7:0] lastpos;
    logic [1:0] lastch;
    do_reset();
    ev_ready = 1'b1; seen = 0;
    up = 4'b0100; down = 4'b0100; tick(); up = '0; down = '0;
    for (int i = 0; i < 4; i++) begin tick(); if (ev_valid) seen++; end
    total++; if (gp(2) !== 8'd0) begin bad++; $display("FAIL cancel_pos got=%0d exp=0", gp(2)); end
    total++; if (seen !== 0) begin bad++; $display("FAIL cancel_events got=%0d exp=0", seen); end
    up = 4'b0100; tick(); tick(); tick(); up = '0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (gp(2) !== 8'd3) begin bad++; $display("FAIL clr_pre got=%0d exp=3", gp(2)); end
    clr = 4'b0100; up = 4'b0100; tick(); clr = '0; up = '0;
    total++; if (gp(2) !== 8'd0) begin bad++; $display("FAIL clr_pos got=%0d exp=0", gp(2)); end
    seen = 0; lastpos = 8'hFF; lastch = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ev_valid) begin seen++; lastpos = ev_pos; lastch = ev_chan; end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL clr_events got=%0d exp=1", seen); end
    total++; if ({lastch, lastpos} !== {2'd2, 8'd0}) begin bad++;
      $display("FAIL clr_event got=%0d/%0d exp=2/0", lastch, lastpos); end
    ev_ready = 1'b0;
  endtask

`ifdef ENC_ACCEL_EN
  task automatic test_accel();
    do_reset();
    ev_ready = 1'b1;
    up = 4'b0001; tick(); up = '0;
    total++; if (gp(0) !== 8'd1) begin bad++; $display("FAIL accel_t0 got=%0d exp=1", gp(0)); end
    for (int i = 0; i < 99; i++) tick();
    up = 4'b0001; tick(); up = '0;
    total++; if (gp(0) !== 8'd5) begin bad++; $display("FAIL accel_t100 got=%0d exp=5", gp(0)); end
    for (int i = 0; i < 1899; i++) tick();
    up = 4'b0001; tick(); up = '0;
    total++; if (gp(0) !== 8'd6) begin bad++; $display("FAIL accel_t2000 got=%0d exp=6", gp(0)); end
    ev_ready = 1'b0;
  endtask
`endif

  initial begin
    up = '0; down = '0; clr = '0; ev_ready = 1'b0; reset_n = 1'b0;
    test_reset();
    test_latency();
    test_saturation();
    test_back_to_back();
    test_hold_stable();
    test_cancel_clr();
`ifdef ENC_ACCEL_EN
    test_accel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
